// File: rtl/mixer_pkg.sv
// Shared definitions for the round-robin frame mixer: FSM states and
// small elaboration-time helpers used to size fields from parameters.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2
  } state_t;

  // The end-of-frame marker always rides in the top bit of a word.
  function automatic int eof_bit(input int width);
    return width - 1;
  endfunction

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/mixer_rr_arbiter.sv
// Combinational rotating priority encoder. In round-robin mode the search
// starts one past the last served port. In fixed mode it always starts at
// port 0, so the lowest requesting index wins.
module mixer_rr_arbiter
  import mixer_pkg::*;
#(
  parameter int NPORT = 5,
  parameter int PW    = clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic             mode,
  output logic [NPORT-1:0] gnt,
  output logic [PW-1:0]    gnt_idx
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk the ports in priority order and pick the first one requesting.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (mode) begin
        idx = PW'(k);
      end else begin
        idx = PW'((int'(ptr) + 1 + k) % NPORT);
      end
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mixer_rr.sv
// N-input frame mixer. It moves whole frames from NPORT first-word-fall-through
// FIFOs into one output FIFO. Once a port owns the output, it keeps it until
// its EOF word is popped. A frame that runs past MAX_WORDS is closed early with
// a forced EOF, and the remainder of that frame is discarded at the input.
module mixer_rr
  import mixer_pkg::*;
#(
  parameter int               NPORT     = 5,
  parameter int               WIDTH     = 72,
  parameter logic [NPORT-1:0] EN_MASK   = {NPORT{1'b1}},
  parameter int               MODE      = 0,
  parameter int               MAX_WORDS = 190
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NPORT*WIDTH-1:0] port_dout,
  input  logic [NPORT-1:0]       port_empty,
  output logic [NPORT-1:0]       port_rd_en,
  output logic [WIDTH-1:0]       din,
  input  logic                   full,
  output logic                   wr_en,
  output logic [NPORT-1:0]       grant,
  output logic                   trunc_err,
  output logic [31:0]            frame_cnt
);

  localparam int PW      = clog2(NPORT);
  localparam int CW      = clog2(MAX_WORDS + 1);
  localparam int EOF_POS = eof_bit(WIDTH);

  state_t           state;
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] arb_gnt;
  logic [PW-1:0]    arb_idx;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gidx;
  logic [CW-1:0]    wcnt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] trunc_word;
  logic             pop;

  assign req = ~port_empty & EN_MASK;

  mixer_rr_arbiter #(
    .NPORT (NPORT),
    .PW    (PW)
  ) u_arbiter (
    .req     (req),
    .ptr     (rr_ptr),
    .mode    (MODE != 0),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Select the head word of the port that currently owns the output.
  always_comb begin
    head = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (gidx == PW'(i)) begin
        head = port_dout[i*WIDTH +: WIDTH];
      end
    end
    trunc_word          = head;
    trunc_word[EOF_POS] = 1'b1;
  end

  // Pop only from the owner. While draining, ignore back-pressure because
  // nothing is written to the output.
  always_comb begin
    port_rd_en = '0;
    case (state)
      XFER:    port_rd_en = grant & ~port_empty & {NPORT{~full}};
      DROP:    port_rd_en = grant & ~port_empty;
      default: port_rd_en = '0;
    endcase
  end

  assign pop = |port_rd_en;

  // Frame FSM. It owns the grant, the fairness pointer, the word counter, the
  // registered output word, and the frame counter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      grant     <= '0;
      gidx      <= '0;
      rr_ptr    <= PW'(NPORT - 1);
      wcnt      <= '0;
      din       <= '0;
      wr_en     <= 1'b0;
      trunc_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wr_en     <= 1'b0;
      trunc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= arb_gnt;
            gidx  <= arb_idx;
            wcnt  <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (pop) begin
            din   <= head;
            wr_en <= 1'b1;
            if (wcnt != CW'(MAX_WORDS)) begin
              wcnt <= wcnt + 1'b1;
            end
            if (head[EOF_POS]) begin
              frame_cnt <= frame_cnt + 32'd1;
              grant     <= '0;
              rr_ptr    <= gidx;
              state     <= IDLE;
            end else if (wcnt == CW'(MAX_WORDS - 1)) begin
              din       <= trunc_word;
              trunc_err <= 1'b1;
              frame_cnt <= frame_cnt + 32'd1;
              state     <= DROP;
            end
          end
        end
        DROP: begin
          if (pop && head[EOF_POS]) begin
            grant  <= '0;
            rr_ptr <= gidx;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
